// File: rtl/gate_array_pipe_if.sv
// Operand/result handshake bundle for gate_array_pipe.
// The master is the stimulus side, and the slave is the gate block.
interface gate_array_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             y_all1;
   logic             y_zero;
   logic [2:0]       op_q;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, y_all1, y_zero, op_q
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, y_all1, y_zero, op_q
   );
endinterface

// File: rtl/gate_array_pipe.sv
// Selectable bitwise two-input gate with a one-stage valid/ready result register.
// Also keeps a saturating count of accepted equal operand pairs.
module gate_array_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   gate_array_pipe_if.slave bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] match_cnt
);
   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_XNOR = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_NOTA = 3'd6,
      OP_BUFA = 3'd7
   } gate_op_e;

   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] y_r;
   logic             y_all1_r;
   logic             y_zero_r;
   logic [2:0]       op_r;
   logic             vld_r;
   logic [CNT_W-1:0] cnt_r;
   logic             in_xfer;
   logic             out_xfer;

   assign bus.in_ready = !vld_r || bus.out_ready;
   assign in_xfer      = bus.in_valid && bus.in_ready;
   assign out_xfer     = vld_r && bus.out_ready;

   always_comb begin
      f = '0;
      case (gate_op_e'(bus.op))
         OP_AND:  f = bus.a & bus.b;
         OP_OR:   f = bus.a | bus.b;
         OP_XOR:  f = bus.a ^ bus.b;
         OP_XNOR: f = ~(bus.a ^ bus.b);
         OP_NAND: f = ~(bus.a & bus.b);
         OP_NOR:  f = ~(bus.a | bus.b);
         OP_NOTA: f = ~bus.a;
         OP_BUFA: f = bus.a;
         default: f = '0;
      endcase
   end

   // Result register: load on accept, otherwise hold; valid drops only on a bare drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r    <= 1'b0;
         y_r      <= '0;
         y_all1_r <= 1'b0;
         y_zero_r <= 1'b1;
         op_r     <= 3'd0;
      end else if (in_xfer) begin
         vld_r    <= 1'b1;
         y_r      <= f;
         y_all1_r <= &f;
         y_zero_r <= ~|f;
         op_r     <= bus.op;
      end else if (out_xfer) begin
         vld_r    <= 1'b0;
      end
   end

   // Clear takes priority over a same-cycle increment; the count never wraps.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt)
         cnt_r <= '0;
      else if (in_xfer && (bus.a == bus.b) && (cnt_r != {CNT_W{1'b1}}))
         cnt_r <= cnt_r + 1'b1;
   end

   assign bus.out_valid = vld_r;
   assign bus.y         = y_r;
   assign bus.y_all1    = y_all1_r;
   assign bus.y_zero    = y_zero_r;
   assign bus.op_q      = op_r;
   assign match_cnt     = cnt_r;
endmodule
